vertex_rs_param: RTL

Parametrised reservation station between the feature-vector bank and the vertex PE array. It collects one SOS/EOS-framed feature-vector stream per node into `NUM_SLOTS` slots and fires once all slots hold a stream. It then serves a `LANES_OUT`-wide window of every slot, selected by `start_idx`, until the vertex side signals `complete`. It is the generalised successor of the fixed 4-slot, 2-lane vertex RS, adding lane/depth parameters, an overflow flag, a per-slot valid mask and optional partial-batch flush.

---
 rtl/vertex_rs_pkg.sv | 30 +++
 rtl/vertex_rs_window.sv | 28 ++
 rtl/vertex_rs_param.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/vertex_rs_pkg.sv
// Shared types and width helpers for the vertex reservation station.
package vertex_rs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    SERVE = 2'd2,
    DRAIN = 2'd3
  } rs_state_t;

  localparam int FV_W_DEF      = 16;
  localparam int NODE_W_DEF    = 8;
  localparam int MAX_FV_DEF    = 16;
  localparam int LANES_IN_DEF  = 2;
  localparam int LANES_OUT_DEF = 2;
  localparam int NUM_SLOTS_DEF = 4;

  function automatic int idx_w(input int max_fv);
    return (max_fv > 1) ? $clog2(max_fv) : 1;
  endfunction

  function automatic int cnt_w(input int num_slots);
    return $clog2(num_slots) + 1;
  endfunction

  function automatic int ptr_w(input int num_slots);
    return (num_slots > 1) ? $clog2(num_slots) : 1;
  endfunction

endpackage

// File: rtl/vertex_rs_window.sv
// Wrap-around window mux: LANES_OUT consecutive elements of one slot from start_idx.
module vertex_rs_window
  import vertex_rs_pkg::*;
#(
  parameter int FV_W      = FV_W_DEF,
  parameter int MAX_FV    = MAX_FV_DEF,
  parameter int LANES_OUT = LANES_OUT_DEF
) (
  input  logic [MAX_FV*FV_W-1:0]    slot_data,
  input  logic [$clog2(MAX_FV)-1:0] start_idx,
  output logic [LANES_OUT*FV_W-1:0] window
);

  localparam int IDX_W = $clog2(MAX_FV);

  logic [IDX_W-1:0] idx;

  // The IDX_W-bit add wraps naturally modulo MAX_FV.
  always_comb begin
    window = '0;
    idx    = '0;
    for (int j = 0; j < LANES_OUT; j++) begin
      idx = start_idx + IDX_W'(j);
      window[j*FV_W +: FV_W] = slot_data[int'(idx)*FV_W +: FV_W];
    end
  end

endmodule

// File: rtl/vertex_rs_param.sv
// Parametrised vertex reservation station: collects NUM_SLOTS node streams, fires, serves windows.
// Optional partial-batch flush is built when VERTEX_RS_FLUSH_EN is defined.
module vertex_rs_param
  import vertex_rs_pkg::*;
#(
  parameter int FV_W      = FV_W_DEF,
  parameter int NODE_W    = NODE_W_DEF,
  parameter int MAX_FV    = MAX_FV_DEF,
  parameter int LANES_IN  = LANES_IN_DEF,
  parameter int LANES_OUT = LANES_OUT_DEF,
  parameter int NUM_SLOTS = NUM_SLOTS_DEF
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_sos,
  input  logic                                 in_eos,
  input  logic [LANES_IN*FV_W-1:0]             in_fv,
  input  logic [NODE_W-1:0]                    in_node_id,
  input  logic [$clog2(MAX_FV)-1:0]            start_idx,
  input  logic                                 vbuf_idle,
  input  logic                                 complete,
`ifdef VERTEX_RS_FLUSH_EN
  input  logic                                 flush,
`endif
  output logic [NUM_SLOTS*LANES_OUT*FV_W-1:0]  out_fv,
  output logic [NUM_SLOTS*NODE_W-1:0]          out_node_id,
  output logic [NUM_SLOTS-1:0]                 out_valid,
  output logic                                 fire,
  output logic                                 rs_available,
  output logic                                 rs_empty,
  output logic                                 overflow
);

  localparam int IDX_W  = idx_w(MAX_FV);
  localparam int CNT_W  = cnt_w(NUM_SLOTS);
  localparam int PTR_W  = ptr_w(NUM_SLOTS);
  localparam int SLOT_W = MAX_FV * FV_W;
  localparam int WIN_W  = LANES_OUT * FV_W;

  rs_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_cur;
  logic [PTR_W-1:0]   wr_ptr;
  logic [IDX_W:0]     fv_idx;

  logic [SLOT_W-1:0]  slot_mem [NUM_SLOTS];
  logic [NODE_W-1:0]  node_mem [NUM_SLOTS];
  logic [WIN_W-1:0]   win      [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_valid;

  logic take_sos, beat, close, in_range, batch_full, flush_req, flush_idle, serve_out;

`ifdef VERTEX_RS_FLUSH_EN
  logic flush_pend;
`endif

  always_comb begin
    take_sos   = (state == IDLE) && in_sos;
    beat       = take_sos || (state == RECV);
    close      = beat && in_eos;
    // fv_idx carries one extra bit so it saturates at MAX_FV instead of wrapping.
    in_range   = (fv_idx < (IDX_W+1)'(MAX_FV));
    cnt_cur    = take_sos ? cnt + CNT_W'(1) : cnt;
    batch_full = (cnt_cur == CNT_W'(NUM_SLOTS));
`ifdef VERTEX_RS_FLUSH_EN
    flush_req  = flush_pend || (beat && flush);
    flush_idle = (state == IDLE) && !in_sos && flush && (cnt != '0);
    for (int s = 0; s < NUM_SLOTS; s++) slot_valid[s] = (CNT_W'(s) < cnt);
`else
    flush_req  = 1'b0;
    flush_idle = 1'b0;
    slot_valid = '1;
`endif
    fire         = (close && (batch_full || flush_req)) || flush_idle;
    rs_available = (state == IDLE);
    rs_empty     = (cnt == '0);
    serve_out    = (state == SERVE) && !complete;
  end

  always_ff @(posedge clk) begin
    if (beat && in_range) begin
      for (int k = 0; k < LANES_IN; k++)
        slot_mem[wr_ptr][(int'(fv_idx) + k)*FV_W +: FV_W] <= in_fv[k*FV_W +: FV_W];
    end
    if (take_sos) node_mem[wr_ptr] <= in_node_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      wr_ptr   <= '0;
      fv_idx   <= '0;
      overflow <= 1'b0;
`ifdef VERTEX_RS_FLUSH_EN
      flush_pend <= 1'b0;
`endif
    end else begin
      if (beat) begin
        cnt <= cnt_cur;
        if (in_range) fv_idx <= fv_idx + (IDX_W+1)'(LANES_IN);
        else          overflow <= 1'b1;
      end
`ifdef VERTEX_RS_FLUSH_EN
      // A flush seen mid-stream (or alongside an SOS) is held until that stream closes.
      if (fire || state == DRAIN) flush_pend <= 1'b0;
      else if (beat && flush)     flush_pend <= 1'b1;
`endif
      case (state)
        IDLE, RECV: begin
          if (close) begin
            fv_idx <= '0;
            if (fire) begin
              wr_ptr <= '0;
              state  <= SERVE;
            end else begin
              wr_ptr <= wr_ptr + PTR_W'(1);
              state  <= IDLE;
            end
          end else if (take_sos) begin
            state <= RECV;
          end else if (flush_idle) begin
            wr_ptr <= '0;
            state  <= SERVE;
          end
        end
        SERVE: if (complete) state <= DRAIN;
        DRAIN: begin
          if (vbuf_idle) begin
            cnt    <= '0;
            wr_ptr <= '0;
            fv_idx <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_win
    vertex_rs_window #(
      .FV_W      (FV_W),
      .MAX_FV    (MAX_FV),
      .LANES_OUT (LANES_OUT)
    ) u_win (
      .slot_data (slot_mem[s]),
      .start_idx (start_idx),
      .window    (win[s])
    );
  end

  // Output register stage: window, ids and mask, zeroed outside an active serve.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_fv      <= '0;
      out_node_id <= '0;
      out_valid   <= '0;
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (serve_out && slot_valid[s]) begin
          out_fv[s*WIN_W +: WIN_W]         <= win[s];
          out_node_id[s*NODE_W +: NODE_W]  <= node_mem[s];
          out_valid[s]                     <= 1'b1;
        end else begin
          out_fv[s*WIN_W +: WIN_W]         <= '0;
          out_node_id[s*NODE_W +: NODE_W]  <= '0;
          out_valid[s]                     <= 1'b0;
        end
      end
    end
  end

endmodule
